spi_adc_responder: RTL and testbench
====================================

Name: spi_adc_responder

Overview:
- SPI responder emulating a 2-channel, 12-bit MCP3202-style ADC.
- Serves as the far end of the SPI link that the board's ADC controller masters. Used as the bus-functional ADC model in simulation, and as a drop-in responder when a second FPGA supplies synthetic accelerator/CdS values.
- Oversamples SCK/CS_N/MOSI on the system clock, decodes the 4-bit command and shifts back a null bit plus the conversion result on MISO.

Parameters:
- DATA_BITS, 12, conversion width.
- SYNC_STAGES, 2, synchroniser depth on spi_sck, spi_cs_n and spi_mosi.

Ports:
- clk  in  1  system clock; SCK half-period must be at least SYNC_STAGES+2 clk.
- rst_n  in  1  asynchronous, active-low reset.
- spi_sck  in  1  SPI clock, mode 0, idle low.
- spi_cs_n  in  1  chip select, active low.
- spi_mosi  in  1  command bits from the master.
- spi_miso  out  1  response data.
- spi_miso_oe  out  1  MISO drive enable; the top level tri-states the pin when this is 0.
- ch0_value  in  DATA_BITS  channel 0 analog value (accelerator).
- ch1_value  in  DATA_BITS  channel 1 analog value (CdS).
- frame_done  out  1  one-clk pulse when the last MSB-first data bit has been driven.
- frame_abort  out  1  one-clk pulse when CS_N rises before frame_done.
- last_cmd  out  3  {SGL, ODD, MSBF} of the most recent decoded command.

Behaviour:
- Reset (rst_n=0, async): state=IDLE; spi_miso=0; spi_miso_oe=0; frame_done=0; frame_abort=0; last_cmd=3'b000; synchronisers preset to sck=0, cs_n=1, mosi=0.
- Edge detect: rise/fall/cs_fall/cs_rise are derived from synchronised signals. Pin-to-action latency is SYNC_STAGES+1 clk.
- MOSI is sampled on SCK rise. MISO is updated only on SCK fall.
- Arithmetic: value registers are DATA_BITS wide and unsigned. Subtraction uses DATA_BITS+1 bits, with sign-bit clamping to 0.
- States:
  - IDLE: spi_miso_oe=0. On cs_fall, go to WAIT_START.
  - WAIT_START: on each rise, if mosi=1 go to CMD with bit count 0. Rises with mosi=0 are leading zeros and are ignored.
  - CMD: capture SGL, ODD, MSBF on the next 3 rises.
    - On the MSBF rise, latch the result:
      - SGL=1: ODD ? ch1_value : ch0_value.
      - SGL=0, ODD=0: ch0_value - ch1_value, clamped to 0 if negative.
      - SGL=0, ODD=1: ch1_value - ch0_value, clamped to 0 if negative.
    - Update last_cmd at the same time, then go to NULLB.
  - NULLB: on the next fall, spi_miso_oe=1 and spi_miso=0 (null bit), then go to MSB.
  - MSB: the next DATA_BITS falls drive B11..B0.
    - frame_done pulses in the clk after B0 is driven.
    - Then go to LSB if MSBF=0, else go to TAIL.
  - LSB: the next DATA_BITS-1 falls drive B1..B11, then go to TAIL.
  - TAIL: every fall drives 0, and spi_miso_oe stays 1.
- Any state except IDLE: on cs_rise, go to IDLE the same clk, with spi_miso_oe=0 and spi_miso=0.
  - If frame_done has not yet pulsed this frame, frame_abort pulses for 1 clk.
  - cs_rise takes priority over a rise or fall detected in the same clk.
- ch0_value/ch1_value changes after the latch point do not affect the frame in progress. The result is latched once per frame.
- cs_fall while not in IDLE cannot occur, because cs_rise always comes first. Glitches shorter than SYNC_STAGES clk are not guaranteed to be filtered.
- rst_n asserted mid-frame: immediate return to reset values. The frame is lost and no abort pulse is produced.

Decomposition:
- Shared package spi_adc_pkg holds:
  - State enum constants (IDLE, WAIT_START, CMD, NULLB, MSB, LSB, TAIL).
  - Command bit positions (SGL=2, ODD=1, MSBF=0).
  - DATA_BITS default.
- One natural sub-module: spi_pin_sync, which is the SYNC_STAGES synchroniser plus edge detector for sck/cs_n/mosi. It outputs registered levels and rise/fall/cs_fall/cs_rise strobes.

Test Plan:
- SGL=1, ODD=0, MSBF=1, ch0=12'hA5C, half-period 8 clk, frame of 0,0,0,0,0,1,1,0,1 + 16 SCK -> MISO bits null=0 then 1010_0101_1100; frame_done=1 once; last_cmd=3'b101.
- SGL=1, ODD=1, MSBF=0, ch1=12'h003 -> MSB-first 0000_0000_0011, then LSB-first 1,0,0,...,0 (11 bits), then zeros; spi_miso_oe=1 throughout.
- Differential SGL=0, ODD=0, ch0=12'h100, ch1=12'h180 -> result 12'h000 (clamped); repeat with ODD=1 -> 12'h080.
- ch0 changes from 12'h111 to 12'hFFF two SCK periods after the MSBF rise -> MISO still returns 12'h111.
- CS_N raised after 5 data bits -> spi_miso_oe=0 within SYNC_STAGES+1 clk; frame_abort pulses 1 clk; frame_done stays 0; next frame returns correct data.
- rst_n pulsed low mid-MSB phase -> spi_miso_oe=0 immediately; last_cmd=3'b000; no frame_done or frame_abort pulse.

Source files
------------

// File: rtl/spi_adc_pkg.sv
// rtl/spi_adc_pkg.sv - shared types and constants for the SPI ADC responder
package spi_adc_pkg;

    localparam int DATA_BITS_DEF = 12;

    // Bit positions inside the 3-bit {SGL, ODD, MSBF} command field
    localparam int CMD_SGL  = 2;
    localparam int CMD_ODD  = 1;
    localparam int CMD_MSBF = 0;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_START,
        CMD,
        NULLB,
        MSB,
        LSB,
        TAIL
    } state_t;

endpackage

// File: rtl/spi_adc_responder_if.sv
// rtl/spi_adc_responder_if.sv - SPI pin bundle between ADC controller and responder
interface spi_adc_responder_if;

    logic spi_sck;
    logic spi_cs_n;
    logic spi_mosi;
    logic spi_miso;
    logic spi_miso_oe;

    modport master (
        output spi_sck,
        output spi_cs_n,
        output spi_mosi,
        input  spi_miso,
        input  spi_miso_oe
    );

    modport slave (
        input  spi_sck,
        input  spi_cs_n,
        input  spi_mosi,
        output spi_miso,
        output spi_miso_oe
    );

endinterface

// File: rtl/spi_pin_sync.sv
// rtl/spi_pin_sync.sv - synchroniser and edge detector for sck/cs_n/mosi
module spi_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sck,
    input  logic cs_n,
    input  logic mosi,
    output logic mosi_q,
    output logic rise,
    output logic fall,
    output logic cs_fall,
    output logic cs_rise
);

    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sck_prev;
    logic                   cs_prev;
    logic                   sck_q;
    logic                   cs_q;

    // Presets match the bus idle levels so reset release never fakes an edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync  <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sck_prev  <= 1'b0;
            cs_prev   <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sck_prev  <= sck_q;
            cs_prev   <= cs_q;
        end
    end

    assign sck_q   = sck_sync[SYNC_STAGES-1];
    assign cs_q    = cs_sync[SYNC_STAGES-1];
    assign mosi_q  = mosi_sync[SYNC_STAGES-1];
    assign rise    = sck_q & ~sck_prev;
    assign fall    = ~sck_q & sck_prev;
    assign cs_fall = ~cs_q & cs_prev;
    assign cs_rise = cs_q & ~cs_prev;

endmodule

// File: rtl/spi_adc_responder.sv
// rtl/spi_adc_responder.sv - MCP3202-style 2-channel ADC responder on an SPI link
module spi_adc_responder
    import spi_adc_pkg::*;
#(
    parameter int DATA_BITS   = DATA_BITS_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    spi_adc_responder_if.slave   spi,
    input  logic [DATA_BITS-1:0] ch0_value,
    input  logic [DATA_BITS-1:0] ch1_value,
    output logic                 frame_done,
    output logic                 frame_abort,
    output logic [2:0]           last_cmd
);

    localparam int CW = $clog2(DATA_BITS);

    logic mosi_q, rise, fall, cs_fall, cs_rise;

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_pin_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .sck     (spi.spi_sck),
        .cs_n    (spi.spi_cs_n),
        .mosi    (spi.spi_mosi),
        .mosi_q  (mosi_q),
        .rise    (rise),
        .fall    (fall),
        .cs_fall (cs_fall),
        .cs_rise (cs_rise)
    );

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [2:0]             cmd_q, cmd_d;
    logic [DATA_BITS-1:0]   result_q, result_d;
    logic                   miso_q, miso_d;
    logic                   oe_q, oe_d;
    logic                   done_q, done_d;
    logic                   abort_q, abort_d;
    logic                   done_seen_q, done_seen_d;
    logic [2:0]             last_cmd_q, last_cmd_d;

    // ODD picks which channel is the minuend in both single and differential modes
    logic [DATA_BITS-1:0]   minuend, subtrahend, diff_val, conv_val;
    logic [DATA_BITS:0]     diff;

    assign minuend    = cmd_q[CMD_ODD] ? ch1_value : ch0_value;
    assign subtrahend = cmd_q[CMD_ODD] ? ch0_value : ch1_value;
    assign diff       = {1'b0, minuend} - {1'b0, subtrahend};
    assign diff_val   = diff[DATA_BITS] ? '0 : diff[DATA_BITS-1:0];
    assign conv_val   = cmd_q[CMD_SGL] ? minuend : diff_val;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cmd_q       <= '0;
            result_q    <= '0;
            miso_q      <= 1'b0;
            oe_q        <= 1'b0;
            done_q      <= 1'b0;
            abort_q     <= 1'b0;
            done_seen_q <= 1'b0;
            last_cmd_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_q       <= cmd_d;
            result_q    <= result_d;
            miso_q      <= miso_d;
            oe_q        <= oe_d;
            done_q      <= done_d;
            abort_q     <= abort_d;
            done_seen_q <= done_seen_d;
            last_cmd_q  <= last_cmd_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cmd_d       = cmd_q;
        result_d    = result_q;
        miso_d      = miso_q;
        oe_d        = oe_q;
        done_d      = 1'b0;
        abort_d     = 1'b0;
        done_seen_d = done_seen_q;
        last_cmd_d  = last_cmd_q;

        // Deselect wins over any SCK edge seen in the same cycle
        if (state_q != IDLE && cs_rise) begin
            state_d = IDLE;
            oe_d    = 1'b0;
            miso_d  = 1'b0;
            abort_d = ~done_seen_q;
        end else begin
            unique case (state_q)
                IDLE: begin
                    oe_d = 1'b0;
                    if (cs_fall) begin
                        state_d     = WAIT_START;
                        done_seen_d = 1'b0;
                    end
                end
                WAIT_START: begin
                    if (rise && mosi_q) begin
                        state_d = CMD;
                        cnt_d   = '0;
                    end
                end
                CMD: begin
                    if (rise) begin
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == '0) begin
                            cmd_d[CMD_SGL] = mosi_q;
                        end else if (cnt_q == CW'(1)) begin
                            cmd_d[CMD_ODD] = mosi_q;
                        end else begin
                            cmd_d[CMD_MSBF] = mosi_q;
                            result_d        = conv_val;
                            last_cmd_d      = {cmd_q[CMD_SGL], cmd_q[CMD_ODD], mosi_q};
                            state_d         = NULLB;
                        end
                    end
                end
                NULLB: begin
                    if (fall) begin
                        oe_d    = 1'b1;
                        miso_d  = 1'b0;
                        cnt_d   = CW'(DATA_BITS - 1);
                        state_d = MSB;
                    end
                end
                MSB: begin
                    if (fall) begin
                        miso_d = result_q[cnt_q];
                        if (cnt_q == '0) begin
                            done_d      = 1'b1;
                            done_seen_d = 1'b1;
                            cnt_d       = CW'(1);
                            state_d     = cmd_q[CMD_MSBF] ? TAIL : LSB;
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end
                end
                LSB: begin
                    if (fall) begin
                        miso_d = result_q[cnt_q];
                        if (cnt_q == CW'(DATA_BITS - 1)) begin
                            state_d = TAIL;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                TAIL: begin
                    if (fall) begin
                        miso_d = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign spi.spi_miso    = miso_q;
    assign spi.spi_miso_oe = oe_q;
    assign frame_done      = done_q;
    assign frame_abort     = abort_q;
    assign last_cmd        = last_cmd_q;

endmodule

// File: tb/tb_spi_adc_responder.sv
// tb/tb_spi_adc_responder.sv - scoreboard bench for the SPI ADC responder
module tb_spi_adc_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] ch0 = 12'h000;
    logic [11:0] ch1 = 12'h000;
    logic        frame_done;
    logic        frame_abort;
    logic [2:0]  last_cmd;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int abort_cnt = 0;
    bit exp_q[$];

    spi_adc_responder_if spi();

    spi_adc_responder #(.DATA_BITS(12), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .spi         (spi),
        .ch0_value   (ch0),
        .ch1_value   (ch1),
        .frame_done  (frame_done),
        .frame_abort (frame_abort),
        .last_cmd    (last_cmd)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done === 1'b1) done_cnt++;
        if (frame_abort === 1'b1) abort_cnt++;
    end

    task automatic half_per();
        repeat (8) @(negedge clk);
    endtask

    function automatic logic [11:0] model(input logic [2:0] c, input logic [11:0] a, input logic [11:0] b);
        int d;
        if (c[2]) return c[1] ? b : a;
        d = c[1] ? (int'(b) - int'(a)) : (int'(a) - int'(b));
        if (d < 0) return 12'h000;
        return d[11:0];
    endfunction

    task automatic push_exp(input logic [11:0] v, input logic msbf, input int n);
        bit b;
        for (int k = 0; k < n; k++) begin
            if (k == 0) b = 1'b0;
            else if (k <= 12) b = v[12-k];
            else if (!msbf && k <= 23) b = v[k-12];
            else b = 1'b0;
            exp_q.push_back(b);
        end
    endtask

    task automatic send_cmd(input logic [2:0] c);
        logic [8:0] bits;
        bits = {5'b00000, 1'b1, c};
        spi.spi_cs_n = 1'b0;
        half_per();
        for (int i = 8; i >= 0; i--) begin
            spi.spi_mosi = bits[i];
            half_per();
            spi.spi_sck = 1'b1;
            half_per();
            spi.spi_sck = 1'b0;
        end
    endtask

    task automatic frame(input string name, input logic [2:0] c, input int nsamp,
                         input int chg_at, input logic [11:0] chg_val);
        int d0, a0, exp_done, exp_abort;
        bit e;
        push_exp(model(c, ch0, ch1), c[0], nsamp);
        d0 = done_cnt;
        a0 = abort_cnt;
        send_cmd(c);
        total++;
        if (last_cmd !== c) begin
            bad++;
            $display("FAIL %s last_cmd: got %b want %b", name, last_cmd, c);
        end
        for (int j = 0; j < nsamp; j++) begin
            spi.spi_mosi = 1'b0;
            half_per();
            if (j == chg_at) ch0 = chg_val;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL %s scoreboard empty at bit %0d: got %b want none", name, j, spi.spi_miso);
            end else begin
                e = exp_q.pop_front();
                if (spi.spi_miso !== e) begin
                    bad++;
                    $display("FAIL %s miso bit %0d: got %b want %b", name, j, spi.spi_miso, e);
                end
            end
            total++;
            if (spi.spi_miso_oe !== 1'b1) begin
                bad++;
                $display("FAIL %s miso_oe bit %0d: got %b want 1", name, j, spi.spi_miso_oe);
            end
            spi.spi_sck = 1'b1;
            half_per();
            spi.spi_sck = 1'b0;
        end
        half_per();
        spi.spi_cs_n = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (spi.spi_miso_oe !== 1'b0 || spi.spi_miso !== 1'b0) begin
            bad++;
            $display("FAIL %s release: got oe=%b miso=%b want oe=0 miso=0", name, spi.spi_miso_oe, spi.spi_miso);
        end
        repeat (8) @(negedge clk);
        exp_done = (nsamp >= 12) ? 1 : 0;
        exp_abort = 1 - exp_done;
        total++;
        if (done_cnt - d0 !== exp_done) begin
            bad++;
            $display("FAIL %s frame_done pulses: got %0d want %0d", name, done_cnt - d0, exp_done);
        end
        total++;
        if (abort_cnt - a0 !== exp_abort) begin
            bad++;
            $display("FAIL %s frame_abort pulses: got %0d want %0d", name, abort_cnt - a0, exp_abort);
        end
    endtask

    task automatic test_reset();
        total++;
        if ({spi.spi_miso, spi.spi_miso_oe, frame_done, frame_abort, last_cmd} !== 7'b0) begin
            bad++;
            $display("FAIL reset outputs: got miso=%b oe=%b done=%b abort=%b cmd=%b want all 0",
                     spi.spi_miso, spi.spi_miso_oe, frame_done, frame_abort, last_cmd);
        end
    endtask

    task automatic test_single_ch0();
        ch0 = 12'hA5C;
        ch1 = 12'h3C3;
        frame("single_ch0", 3'b101, 16, -1, 12'h000);
    endtask

    task automatic test_single_ch1_lsb();
        ch0 = 12'hFFF;
        ch1 = 12'h003;
        frame("single_ch1_lsb", 3'b110, 28, -1, 12'h000);
    endtask

    task automatic test_diff();
        ch0 = 12'h100;
        ch1 = 12'h180;
        frame("diff_clamp", 3'b001, 16, -1, 12'h000);
        frame("diff_odd", 3'b011, 16, -1, 12'h000);
    endtask

    task automatic test_latch_hold();
        ch0 = 12'h111;
        ch1 = 12'h000;
        frame("latch_hold", 3'b101, 16, 2, 12'hFFF);
    endtask

    task automatic test_abort();
        ch0 = 12'h5A3;
        frame("abort", 3'b101, 6, -1, 12'h000);
        exp_q.delete();
        ch0 = 12'hC35;
        frame("after_abort", 3'b101, 16, -1, 12'h000);
    endtask

    task automatic test_reset_mid();
        int d0, a0;
        ch0 = 12'h777;
        d0 = done_cnt;
        a0 = abort_cnt;
        send_cmd(3'b101);
        for (int j = 0; j < 5; j++) begin
            half_per();
            spi.spi_sck = 1'b1;
            half_per();
            spi.spi_sck = 1'b0;
        end
        total++;
        if (last_cmd !== 3'b101 || spi.spi_miso_oe !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid pre: got cmd=%b oe=%b want cmd=101 oe=1", last_cmd, spi.spi_miso_oe);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (spi.spi_miso_oe !== 1'b0 || last_cmd !== 3'b000 || spi.spi_miso !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid async: got oe=%b cmd=%b miso=%b want 0 000 0",
                     spi.spi_miso_oe, last_cmd, spi.spi_miso);
        end
        spi.spi_cs_n = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        total++;
        if (done_cnt - d0 !== 0 || abort_cnt - a0 !== 0) begin
            bad++;
            $display("FAIL reset_mid pulses: got done=%0d abort=%0d want 0 0", done_cnt - d0, abort_cnt - a0);
        end
    endtask

    initial begin
        spi.spi_sck = 1'b0;
        spi.spi_cs_n = 1'b1;
        spi.spi_mosi = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        test_single_ch0();
        test_single_ch1_lsb();
        test_diff();
        test_latch_hold();
        test_abort();
        test_reset_mid();
        frame("post_reset", 3'b111, 16, -1, 12'h000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
